// File: rtl/sparse_tree_sum_generator.sv
// ---------------------------------------------------------------------------
// sparse_tree_sum_generator
//
// Consumer end of a 4-sparse carry tree adder. Each 4-bit group precomputes
// its sum for a group carry-in of 0 and of 1, and the group carry supplied by
// the carry generator picks one of the two (carry-select). The supplied
// carries are trusted; they are never checked against the operands.
//
// Two-stage pipeline with valid/ready handshakes on both sides:
//   S1 : per-group sum pair + per-group select bit + carry_out
//   S2 : selected sum, carry_out (and overflow)
// An accepted bundle reaches the outputs two cycles later when nothing stalls,
// and a full pipe accepts and delivers in the same cycle without a bubble.
//
// Optional feature: define SPARSE_SUM_OVERFLOW_EN to add the signed overflow
// output, registered together with sum.
//
// Parameters:
//   N_BIT      operand width, multiple of 4, >= 8
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand/carry bundle valid
//   in_ready   bundle accepted this cycle (combinational, independent of in_valid)
//   operand_1  addend A
//   operand_2  addend B
//   carry_in   adder carry-in
//   carries    carries[j] = carry out of bits 4j+3..0
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        A + B + carry_in, mod 2^N_BIT
//   carry_out  carries[N_BIT/4-1] of the same bundle
//   overflow   signed overflow (only with SPARSE_SUM_OVERFLOW_EN)
// ---------------------------------------------------------------------------
module sparse_tree_sum_generator #(
    parameter int N_BIT = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_BIT-1:0]   operand_1,
    input  logic [N_BIT-1:0]   operand_2,
    input  logic               carry_in,
    input  logic [N_BIT/4-1:0] carries,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_BIT-1:0]   sum,
    output logic               carry_out
`ifdef SPARSE_SUM_OVERFLOW_EN
    ,
    output logic               overflow
`endif
);

    localparam int G = N_BIT / 4;

    typedef logic [G-1:0][3:0] nibbles_t;

    // -----------------------------------------------------------------------
    // Handshake / stall control
    // -----------------------------------------------------------------------
    logic s1_valid;
    logic s2_advance;
    logic s1_advance;
    logic accept;

    assign s2_advance = !out_valid || out_ready;
    assign s1_advance = !s1_valid || s2_advance;
    assign in_ready   = s1_advance;
    assign accept     = in_valid && in_ready;

    // -----------------------------------------------------------------------
    // S1 combinational precompute
    // -----------------------------------------------------------------------
    nibbles_t       s0_d;
    nibbles_t       s1_d;
    logic [G-1:0]   sel_d;

    // NOTE: every signal driven in an always_comb gets a default before any
    // conditional or loop assignment, so no path can leave it unassigned and
    // infer a latch.
    always_comb begin
        s0_d = '0;
        s1_d = '0;
        for (int j = 0; j < G; j++) begin
            s0_d[j] = operand_1[4*j +: 4] + operand_2[4*j +: 4];
            s1_d[j] = s0_d[j] + 4'd1;
        end
    end

    // Group 0 takes the adder carry-in; group j takes the carry out of group j-1.
    assign sel_d = {carries[G-2:0], carry_in};

`ifdef SPARSE_SUM_OVERFLOW_EN
    // Carry into the MSB for both possible carry-ins of the top group: the
    // carry out of that group's low three bits.
    logic [3:0] msb_sum0;
    logic [3:0] msb_sum1;

    assign msb_sum0 = {1'b0, operand_1[N_BIT-2 -: 3]} + {1'b0, operand_2[N_BIT-2 -: 3]};
    assign msb_sum1 = msb_sum0 + 4'd1;
`endif

    // -----------------------------------------------------------------------
    // S1 registers
    // -----------------------------------------------------------------------
    nibbles_t       s0_q;
    nibbles_t       s1_q;
    logic [G-1:0]   sel_q;
    logic           carry_out_s1;
`ifdef SPARSE_SUM_OVERFLOW_EN
    logic           msb_c0_q;
    logic           msb_c1_q;
`endif

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of block ordering.
    // NOTE: the stage data registers are reset along with the valid bits so a
    // discarded bundle never leaves visible or stale data behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s0_q         <= '0;
            s1_q         <= '0;
            sel_q        <= '0;
            carry_out_s1 <= 1'b0;
`ifdef SPARSE_SUM_OVERFLOW_EN
            msb_c0_q     <= 1'b0;
            msb_c1_q     <= 1'b0;
`endif
        end else if (accept) begin
            s1_valid     <= 1'b1;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            sel_q        <= sel_d;
            carry_out_s1 <= carries[G-1];
`ifdef SPARSE_SUM_OVERFLOW_EN
            msb_c0_q     <= msb_sum0[3];
            msb_c1_q     <= msb_sum1[3];
`endif
        end else if (s1_advance) begin
            // Contents moved on (or stage was already empty); data held as-is.
            s1_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // S2 select
    // -----------------------------------------------------------------------
    logic [N_BIT-1:0] sum_d;

    always_comb begin
        sum_d = '0;
        for (int j = 0; j < G; j++) begin
            sum_d[4*j +: 4] = sel_q[j] ? s1_q[j] : s0_q[j];
        end
    end

`ifdef SPARSE_SUM_OVERFLOW_EN
    logic overflow_d;
    assign overflow_d = (sel_q[G-1] ? msb_c1_q : msb_c0_q) ^ carry_out_s1;
`endif

    // -----------------------------------------------------------------------
    // S2 registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
`ifdef SPARSE_SUM_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum       <= sum_d;
                carry_out <= carry_out_s1;
`ifdef SPARSE_SUM_OVERFLOW_EN
                overflow  <= overflow_d;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sparse_tree_sum_generator.sv
// ---------------------------------------------------------------------------
// tb_sparse_tree_sum_generator
//
// Self-checking bench for sparse_tree_sum_generator (N_BIT = 32). Inputs are
// driven just after the falling edge; outputs are sampled 1 time unit later,
// well away from the rising edge. Expected results come from plain integer
// addition of A + B + carry_in, or from group-wise addition with the supplied
// carries when those carries are deliberately inconsistent.
// ---------------------------------------------------------------------------
module tb_sparse_tree_sum_generator;

    localparam int N = 32;
    localparam int G = N / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] operand_1;
    logic [N-1:0] operand_2;
    logic         carry_in;
    logic [G-1:0] carries;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         carry_out;
`ifdef SPARSE_SUM_OVERFLOW_EN
    logic         overflow;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    sparse_tree_sum_generator #(.N_BIT(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .carry_in  (carry_in),
        .carries   (carries),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef SPARSE_SUM_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    // Carry out of bits 4j+3..0 of the true sum A + B + cin.
    function automatic logic [G-1:0] model_carries(logic [N-1:0] a, logic [N-1:0] b, logic cin);
        logic [G-1:0] c;
        logic [63:0]  m;
        logic [63:0]  t;
        for (int j = 0; j < G; j++) begin
            m    = (64'd1 << (4*j + 4)) - 64'd1;
            t    = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, cin};
            c[j] = t[4*j + 4];
        end
        return c;
    endfunction

    function automatic exp_t make_exp(logic [N-1:0] a, logic [N-1:0] b, logic cin);
        exp_t       e;
        logic [N:0] w;
        w    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        e.s  = w[N-1:0];
        e.co = w[N];
        e.ov = (a[N-1] == b[N-1]) && (e.s[N-1] != a[N-1]);
        return e;
    endfunction

    // Result of carry-select when each group is handed an arbitrary carry-in.
    function automatic logic [N-1:0] group_sum(logic [N-1:0] a, logic [N-1:0] b, logic cin,
                                               logic [G-1:0] c);
        logic [N-1:0] r;
        int           gsum;
        int           gcin;
        r = '0;
        for (int j = 0; j < G; j++) begin
            if (j == 0) gcin = int'(cin);
            else        gcin = int'(c[j-1]);
            gsum = int'(a[4*j +: 4]) + int'(b[4*j +: 4]) + gcin;
            r[4*j +: 4] = 4'(gsum % 16);
        end
        return r;
    endfunction

    task automatic drive(logic [N-1:0] a, logic [N-1:0] b, logic cin, logic [G-1:0] c);
        operand_1 = a;
        operand_2 = b;
        carry_in  = cin;
        carries   = c;
    endtask

    task automatic rand_operands(output logic [N-1:0] a, output logic [N-1:0] b, output logic cin);
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            0: a = '1;
            1: b = ~a;
            2: begin a = 32'h7FFF_FFFF; b = 32'h0000_0001; end
            default: ;
        endcase
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive('0, '0, 1'b0, '0);
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h want 0", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry_out: got %b want 0", carry_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_all_ones_carry();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(32'hFFFF_FFFF, 32'h0, 1'b1, 8'hFF);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ones_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_latency_early: got out_valid=%b want 0", out_valid); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_latency: got out_valid=%b want 1", out_valid); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL ones_sum: got %h want 00000000", sum); end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL ones_carry_out: got %b want 1", carry_out); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_drain: got out_valid=%b want 0", out_valid); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [N-1:0] a_arr[9];
        logic [N-1:0] b_arr[9];
        logic         c_arr[9];
        int           idx;
        int           got;
        int           last_cyc;
        exp_t         e;
        a_arr[0] = 32'h1234_5678;
        b_arr[0] = 32'h1111_1111;
        c_arr[0] = 1'b0;
        for (int i = 1; i < 9; i++) rand_operands(a_arr[i], b_arr[i], c_arr[i]);
        exp_q.delete();
        idx      = 0;
        got      = 0;
        last_cyc = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (idx < 9);
            if (idx < 9) drive(a_arr[idx], b_arr[idx], c_arr[idx], model_carries(a_arr[idx], b_arr[idx], c_arr[idx]));
            #1;
            if (in_valid) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(make_exp(a_arr[idx], b_arr[idx], c_arr[idx]));
                idx++;
            end
            if (out_valid === 1'b1) begin
                if (got == 0) begin
                    checks++; if (sum !== 32'h2345_6789) begin errors++; $display("FAIL b2b_directed_sum: got %h want 23456789", sum); end
                end
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL b2b_extra_output: got sum=%h want no output", sum);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if (sum !== e.s || carry_out !== e.co) begin
                        errors++; $display("FAIL b2b_result: got %h/%b want %h/%b", sum, carry_out, e.s, e.co);
                    end
                end
                if (last_cyc >= 0) begin
                    checks++; if (cyc != last_cyc + 1) begin errors++; $display("FAIL b2b_gap: got cycle %0d want %0d", cyc, last_cyc + 1); end
                end
                last_cyc = cyc;
                got++;
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 9) begin errors++; $display("FAIL b2b_count: got %0d results want 9", got); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_stall();
        logic [N-1:0] a[3];
        logic [N-1:0] b[3];
        logic         c[3];
        exp_t         e[3];
        int           k;
        logic         b2_taken;
        for (int i = 0; i < 3; i++) begin
            rand_operands(a[i], b[i], c[i]);
            e[i] = make_exp(a[i], b[i], c[i]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            drive(a[i], b[i], c[i], model_carries(a[i], b[i], c[i]));
            #1;
            if (i < 2) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_accept%0d: got in_ready=%b want 1", i, in_ready); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
            checks++; if (out_valid !== 1'b1 || sum !== e[0].s) begin
                errors++; $display("FAIL stall_hold: got valid=%b sum=%h want 1/%h", out_valid, sum, e[0].s);
            end
        end
        k        = 0;
        b2_taken = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (b2_taken) in_valid = 1'b0;
            #1;
            if (in_valid && in_ready) b2_taken = 1'b1;
            if (out_valid === 1'b1) begin
                checks++;
                if (k >= 3) begin
                    errors++; $display("FAIL stall_extra: got sum=%h want no output", sum);
                end else if (sum !== e[k].s || carry_out !== e[k].co) begin
                    errors++; $display("FAIL stall_order%0d: got %h/%b want %h/%b", k, sum, carry_out, e[k].s, e[k].co);
                end
                k++;
            end
        end
        in_valid = 1'b0;
        checks++; if (k != 3) begin errors++; $display("FAIL stall_count: got %0d want 3", k); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_midflight();
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         c;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            rand_operands(a, b, c);
            a[N-1] = 1'b1;
            drive(a, b, c, model_carries(a, b, c) | 8'h80);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_full: got valid=%b ready=%b want 1/0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        checks++; if (sum !== '0) begin errors++; $display("FAIL rstmid_sum: got %h want 0", sum); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL rstmid_carry_out: got %b want 0", carry_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got out_valid=%b want 0", out_valid); end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_inconsistent_carries();
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         c;
        logic [G-1:0] cr;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                a = 32'h0000_000F; b = 32'h0000_0001; c = 1'b0; cr = 8'h00;
            end else begin
                rand_operands(a, b, c);
                cr = G'($urandom);
            end
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            drive(a, b, c, cr);
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || sum !== group_sum(a, b, c, cr) || carry_out !== cr[G-1]) begin
                errors++; $display("FAIL inconsistent%0d: got %b/%h/%b want 1/%h/%b", i, out_valid, sum, carry_out,
                                   group_sum(a, b, c, cr), cr[G-1]);
            end
        end
    endtask

`ifdef SPARSE_SUM_OVERFLOW_EN
    // -----------------------------------------------------------------------
    task automatic test_overflow();
        logic [N-1:0] a[2];
        logic [N-1:0] b[2];
        logic [N-1:0] want_s[2];
        logic         want_co[2];
        a[0] = 32'h7FFF_FFFF; b[0] = 32'h0000_0001; want_s[0] = 32'h8000_0000; want_co[0] = 1'b0;
        a[1] = 32'h8000_0000; b[1] = 32'h8000_0000; want_s[1] = 32'h0000_0000; want_co[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            drive(a[i], b[i], 1'b0, model_carries(a[i], b[i], 1'b0));
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            #1;
            checks++; if (sum !== want_s[i] || carry_out !== want_co[i] || overflow !== 1'b1) begin
                errors++; $display("FAIL overflow%0d: got %h/%b/%b want %h/%b/1", i, sum, carry_out, overflow,
                                   want_s[i], want_co[i]);
            end
        end
    endtask
`endif

    // -----------------------------------------------------------------------
    task automatic test_random();
        int           sent;
        int           recv;
        int           cyc;
        logic         pending;
        logic         hold_chk;
        logic [N-1:0] prev_sum;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         c;
        exp_t         e;
        exp_q.delete();
        sent     = 0;
        recv     = 0;
        cyc      = 0;
        pending  = 1'b0;
        hold_chk = 1'b0;
        prev_sum = '0;
        a = '0; b = '0; c = 1'b0;
        while (recv < 10000 && cyc < 60000) begin
            @(negedge clk);
            if (!pending && sent < 10000) begin
                rand_operands(a, b, c);
                pending = 1'b1;
            end
            in_valid  = pending && ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            drive(a, b, c, model_carries(a, b, c));
            #1;
            if (hold_chk) begin
                checks++; if (out_valid !== 1'b1 || sum !== prev_sum) begin
                    errors++; $display("FAIL rand_hold: got %b/%h want 1/%h", out_valid, sum, prev_sum);
                end
            end
            hold_chk = (out_valid === 1'b1) && !out_ready;
            prev_sum = sum;
            if (in_valid && in_ready) begin
                exp_q.push_back(make_exp(a, b, c));
                pending = 1'b0;
                sent++;
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra: got sum=%h want no output", sum);
                end else begin
                    e = exp_q.pop_front();
`ifdef SPARSE_SUM_OVERFLOW_EN
                    if (sum !== e.s || carry_out !== e.co || overflow !== e.ov) begin
                        errors++; $display("FAIL rand_result%0d: got %h/%b/%b want %h/%b/%b", recv, sum, carry_out,
                                           overflow, e.s, e.co, e.ov);
                    end
`else
                    if (sum !== e.s || carry_out !== e.co) begin
                        errors++; $display("FAIL rand_result%0d: got %h/%b want %h/%b", recv, sum, carry_out, e.s, e.co);
                    end
`endif
                end
                recv++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (recv != 10000) begin errors++; $display("FAIL rand_count: got %0d results want 10000", recv); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover: got %0d pending want 0", exp_q.size()); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_duplicate: got out_valid=%b want 0", out_valid); end
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_all_ones_carry();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_inconsistent_carries();
`ifdef SPARSE_SUM_OVERFLOW_EN
        test_overflow();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation time limit want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
